// File: rtl/linear_pkg.sv
// Shared definitions for the fixed-point linear-layer engines:
// FSM state encoding, Q16.16 constants and the fixed-point multiply.
package linear_pkg;

  localparam int FRAC_BITS = 16;
  localparam logic [31:0] FX_ONE = 32'h0001_0000;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_B,
    ST_LD_B,
    ST_RD_X,
    ST_RD_W,
    ST_MAC,
    ST_WB,
    ST_DONE
  } state_t;

  // Signed 32x32 -> 64 product, arithmetic shift right (rounds toward
  // minus infinity), keep the low 32 bits.
  function automatic word_t fx_mul(input word_t a, input word_t b, input int frac);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] prod;
    logic signed [63:0] shifted;
    sa      = {{32{a[31]}}, a};
    sb      = {{32{b[31]}}, b};
    prod    = sa * sb;
    shifted = prod >>> frac;
    return shifted[31:0];
  endfunction

endpackage

// File: rtl/linear_forward_if.sv
// Single-port word-addressed memory bus. The engine is the master;
// read data returns the cycle after the read strobe.
interface linear_forward_if #(
  parameter int ADDR_W = 16
);
  import linear_pkg::*;

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  word_t             mem_wdata;
  word_t             mem_rdata;

  modport master (
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/linear_forward_fx_mac.sv
// Combinational fixed-point multiply-accumulate: sum = acc + fx_mul(a, b).
// The add wraps modulo 2^32; there is no saturation.
module fx_mac #(
  parameter int FRAC_BITS = linear_pkg::FRAC_BITS
) (
  input  logic [31:0] acc,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  import linear_pkg::*;

  // One product term added to the running sum.
  always_comb begin
    sum = acc + fx_mul(a, b, FRAC_BITS);
  end

endmodule

// File: rtl/linear_forward.sv
// Fully-connected forward pass: y[i] = b[i] + sum_j W[i][j] * x[j],
// Q16.16 operands fetched from and results stored to one memory port.
// Weights are walked with a running pointer since W is row-major and
// consumed in exactly storage order.
module linear_forward #(
  parameter int ADDR_W    = 16,
  parameter int DIM_W     = 8,
  parameter int FRAC_BITS = linear_pkg::FRAC_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DIM_W-1:0]  in_dim,
  input  logic [DIM_W-1:0]  out_dim,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] y_base,
  linear_forward_if.master  mem,
  output logic              busy,
  output logic              done
);
  import linear_pkg::*;

  state_t            state_reg, state_next;
  logic [DIM_W-1:0]  k_reg, n_reg, i_reg, j_reg;
  logic [ADDR_W-1:0] x_base_reg, b_base_reg, y_base_reg, w_ptr_reg;
  logic [31:0]       acc_reg, x_reg;
  logic [31:0]       mac_sum;

  logic              re_next, we_next;
  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       wdata_next;
  logic              last_j, last_i;

  assign last_j = (j_reg == k_reg - DIM_W'(1));
  assign last_i = (i_reg == n_reg - DIM_W'(1));

  fx_mac #(.FRAC_BITS(FRAC_BITS)) u_mac (
    .acc (acc_reg),
    .a   (x_reg),
    .b   (mem.mem_rdata),
    .sum (mac_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and memory strobes; address/data held at zero when idle.
  always_comb begin
    state_next = state_reg;
    re_next    = 1'b0;
    we_next    = 1'b0;
    addr_next  = '0;
    wdata_next = '0;
    case (state_reg)
      ST_IDLE: begin
        if (go) state_next = (out_dim == '0) ? ST_DONE : ST_RD_B;
      end
      ST_RD_B: begin
        re_next    = 1'b1;
        addr_next  = b_base_reg + ADDR_W'(i_reg);
        state_next = ST_LD_B;
      end
      ST_LD_B: begin
        state_next = (k_reg == '0) ? ST_WB : ST_RD_X;
      end
      ST_RD_X: begin
        re_next    = 1'b1;
        addr_next  = x_base_reg + ADDR_W'(j_reg);
        state_next = ST_RD_W;
      end
      ST_RD_W: begin
        re_next    = 1'b1;
        addr_next  = w_ptr_reg;
        state_next = ST_MAC;
      end
      ST_MAC: begin
        state_next = last_j ? ST_WB : ST_RD_X;
      end
      ST_WB: begin
        we_next    = 1'b1;
        addr_next  = y_base_reg + ADDR_W'(i_reg);
        wdata_next = acc_reg;
        state_next = last_i ? ST_DONE : ST_RD_B;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mem.mem_re    = re_next;
  assign mem.mem_we    = we_next;
  assign mem.mem_addr  = addr_next;
  assign mem.mem_wdata = wdata_next;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = (state_reg == ST_DONE);

  // Parameter latch, loop counters, weight pointer and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg      <= '0;
      n_reg      <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
      x_base_reg <= '0;
      b_base_reg <= '0;
      y_base_reg <= '0;
      w_ptr_reg  <= '0;
      acc_reg    <= '0;
      x_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (go) begin
            k_reg      <= in_dim;
            n_reg      <= out_dim;
            x_base_reg <= x_base;
            b_base_reg <= b_base;
            y_base_reg <= y_base;
            w_ptr_reg  <= w_base;
            i_reg      <= '0;
            j_reg      <= '0;
          end
        end
        ST_LD_B: begin
          acc_reg <= mem.mem_rdata;
          j_reg   <= '0;
        end
        ST_RD_W: begin
          x_reg <= mem.mem_rdata;
        end
        ST_MAC: begin
          acc_reg   <= mac_sum;
          w_ptr_reg <= w_ptr_reg + ADDR_W'(1);
          j_reg     <= j_reg + DIM_W'(1);
        end
        ST_WB: begin
          if (!last_i) i_reg <= i_reg + DIM_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_forward.sv
// Directed bench for linear_forward: behavioural memory on the bus,
// hand-computed Q16.16 results, cycle-exact done timing and access counts.
module tb_linear_forward;
  import linear_pkg::*;

  logic        clk = 1'b0;
  logic        rst, go;
  logic [7:0]  in_dim, out_dim;
  logic [15:0] x_base, w_base, b_base, y_base;
  logic        busy, done;

  linear_forward_if #(.ADDR_W(16)) bus ();

  linear_forward #(.ADDR_W(16), .DIM_W(8), .FRAC_BITS(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .in_dim  (in_dim),
    .out_dim (out_dim),
    .x_base  (x_base),
    .w_base  (w_base),
    .b_base  (b_base),
    .y_base  (y_base),
    .mem     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  int n_rd, n_wr, n_done, n_viol;
  int checks = 0;
  int errors = 0;

  // Memory model plus bus monitor.
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    else            bus.mem_rdata <= 32'hDEAD_BEEF;
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_re) n_rd++;
    if (bus.mem_we) n_wr++;
    if (done) n_done++;
    if (bus.mem_re && bus.mem_we) n_viol++;
    if (!bus.mem_re && !bus.mem_we && bus.mem_addr != 16'h0) n_viol++;
    if (!bus.mem_we && bus.mem_wdata != 32'h0) n_viol++;
  end

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; n_done = 0; n_viol = 0;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
  endtask

  task automatic load_basic();
    clear_mem();
    mem[16'h0100] = FX_ONE;       mem[16'h0101] = 32'h0000_8000;
    mem[16'h0200] = 32'h0001_0000; mem[16'h0201] = 32'h0002_0000;
    mem[16'h0202] = 32'h0003_0000; mem[16'h0203] = 32'h0004_0000;
    mem[16'h0300] = 32'h0;        mem[16'h0301] = FX_ONE;
    mem[16'h0400] = 32'hAAAA_AAAA; mem[16'h0401] = 32'hAAAA_AAAA;
  endtask

  // Launch a run (go accepted in cycle 0) and report the cycle where done
  // is high (-1 on timeout) and whether the engine is idle one cycle later.
  // pulse_cyc >= 0 raises go and scrambles the parameter inputs in that cycle.
  task automatic run(input logic [7:0] n, input logic [7:0] k, input logic [15:0] yb,
                     input int pulse_cyc, output int done_cyc, output logic idle_after);
    int cyc;
    @(negedge clk);
    out_dim = n; in_dim = k;
    x_base = 16'h0100; w_base = 16'h0200; b_base = 16'h0300; y_base = yb;
    clear_counts();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    cyc = 1;
    done_cyc = -1;
    idle_after = 1'b0;
    while (cyc < 3000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      go = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) begin
        out_dim = 8'd7; in_dim = 8'd0; y_base = 16'h5000; b_base = 16'h6000;
      end
      @(posedge clk); #1;
      cyc++;
    end
    go = 1'b0;
    @(posedge clk); #1;
    idle_after = !busy && !done;
    $display("run N=%0d K=%0d: done in cycle %0d, reads=%0d writes=%0d", n, k, done_cyc, n_rd, n_wr);
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0;
    out_dim = '0; in_dim = '0; x_base = '0; w_base = '0; b_base = '0; y_base = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin errors++;
      $display("FAIL reset_strobes: got re=%b we=%b expected 0 0", bus.mem_re, bus.mem_we); end
    checks++; if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 32'h0) begin errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h expected 0 0", bus.mem_addr, bus.mem_wdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_basic_2x2();
    int dc; logic idle;
    load_basic();
    run(8'd2, 8'd2, 16'h0400, -1, dc, idle);
    checks++; if (mem[16'h0400] !== 32'h0002_0000) begin errors++; $display("FAIL basic_y0: got %h expected 00020000", mem[16'h0400]); end
    checks++; if (mem[16'h0401] !== 32'h0006_0000) begin errors++; $display("FAIL basic_y1: got %h expected 00060000", mem[16'h0401]); end
    checks++; if (dc !== 19) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 19", dc); end
    checks++; if (n_wr !== 2) begin errors++; $display("FAIL basic_writes: got %0d expected 2", n_wr); end
    checks++; if (n_rd !== 10) begin errors++; $display("FAIL basic_reads: got %0d expected 10", n_rd); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", n_done); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL basic_idle_after: got %b expected 1", idle); end
    checks++; if (n_viol !== 0) begin errors++; $display("FAIL basic_bus_rules: got %0d violations expected 0", n_viol); end
  endtask

  task automatic test_k0();
    int dc; logic idle;
    clear_mem();
    mem[16'h0300] = 32'h1111_1111; mem[16'h0301] = 32'hFFFF_0000; mem[16'h0302] = 32'h0000_0007;
    // y_base at the top of memory: y[1], y[2] wrap to 0x0000, 0x0001
    run(8'd3, 8'd0, 16'hFFFF, -1, dc, idle);
    checks++; if (mem[16'hFFFF] !== 32'h1111_1111) begin errors++; $display("FAIL k0_y0: got %h expected 11111111", mem[16'hFFFF]); end
    checks++; if (mem[16'h0000] !== 32'hFFFF_0000) begin errors++; $display("FAIL k0_y1: got %h expected ffff0000", mem[16'h0000]); end
    checks++; if (mem[16'h0001] !== 32'h0000_0007) begin errors++; $display("FAIL k0_y2: got %h expected 00000007", mem[16'h0001]); end
    checks++; if (dc !== 10) begin errors++; $display("FAIL k0_done_cycle: got %0d expected 10", dc); end
    checks++; if (n_rd !== 3) begin errors++; $display("FAIL k0_reads: got %0d expected 3", n_rd); end
    checks++; if (n_wr !== 3) begin errors++; $display("FAIL k0_writes: got %0d expected 3", n_wr); end
  endtask

  task automatic test_n0();
    int dc; logic idle;
    clear_mem();
    run(8'd0, 8'd2, 16'h0400, -1, dc, idle);
    checks++; if (dc !== 1) begin errors++; $display("FAIL n0_done_cycle: got %0d expected 1", dc); end
    checks++; if (n_rd !== 0 || n_wr !== 0) begin errors++; $display("FAIL n0_accesses: got rd=%0d wr=%0d expected 0 0", n_rd, n_wr); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL n0_idle_after: got %b expected 1", idle); end
  endtask

  task automatic test_sign_floor();
    int dc; logic idle;
    clear_mem();
    mem[16'h0100] = 32'h0000_0001; mem[16'h0200] = 32'hFFFE_8000; mem[16'h0300] = 32'h0;
    run(8'd1, 8'd1, 16'h0400, -1, dc, idle);
    checks++; if (mem[16'h0400] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sign_floor_y: got %h expected fffffffe", mem[16'h0400]); end
    checks++; if (dc !== 7) begin errors++; $display("FAIL sign_floor_done_cycle: got %0d expected 7", dc); end
  endtask

  task automatic test_overflow_wrap();
    int dc; logic idle;
    clear_mem();
    mem[16'h0100] = 32'h7FFF_0000; mem[16'h0200] = 32'h7FFF_0000; mem[16'h0300] = 32'h0;
    run(8'd1, 8'd1, 16'h0400, -1, dc, idle);
    checks++; if (mem[16'h0400] !== 32'h0001_0000) begin errors++; $display("FAIL overflow_y: got %h expected 00010000", mem[16'h0400]); end
  endtask

  task automatic test_go_ignored();
    int dc; logic idle;
    load_basic();
    run(8'd2, 8'd2, 16'h0400, 3, dc, idle);
    checks++; if (mem[16'h0400] !== 32'h0002_0000) begin errors++; $display("FAIL go_ignored_y0: got %h expected 00020000", mem[16'h0400]); end
    checks++; if (mem[16'h0401] !== 32'h0006_0000) begin errors++; $display("FAIL go_ignored_y1: got %h expected 00060000", mem[16'h0401]); end
    checks++; if (dc !== 19) begin errors++; $display("FAIL go_ignored_done_cycle: got %0d expected 19", dc); end
    checks++; if (n_wr !== 2 || n_done !== 1) begin errors++; $display("FAIL go_ignored_counts: got wr=%0d done=%0d expected 2 1", n_wr, n_done); end
  endtask

  task automatic test_reset_mid_run();
    int cyc; int dc; logic idle;
    load_basic();
    @(negedge clk);
    out_dim = 8'd2; in_dim = 8'd2;
    x_base = 16'h0100; w_base = 16'h0200; b_base = 16'h0300; y_base = 16'h0400;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_status: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 32'h0) begin errors++;
      $display("FAIL midrst_bus: got re=%b we=%b addr=%h wdata=%h expected all 0", bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    rst = 1'b0;
    clear_counts();
    repeat (20) @(posedge clk);
    #1;
    $display("reset mid-run: after abort reads=%0d writes=%0d done=%0d", n_rd, n_wr, n_done);
    checks++; if (n_rd !== 0 || n_wr !== 0 || n_done !== 0) begin errors++;
      $display("FAIL midrst_quiet: got rd=%0d wr=%0d done=%0d expected 0 0 0", n_rd, n_wr, n_done); end
    checks++; if (mem[16'h0400] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL midrst_no_write: got %h expected aaaaaaaa", mem[16'h0400]); end
    run(8'd2, 8'd2, 16'h0400, -1, dc, idle);
    checks++; if (dc !== 19) begin errors++; $display("FAIL midrst_rerun_done_cycle: got %0d expected 19", dc); end
    checks++; if (mem[16'h0401] !== 32'h0006_0000) begin errors++; $display("FAIL midrst_rerun_y1: got %h expected 00060000", mem[16'h0401]); end
  endtask

  initial begin
    test_reset();
    test_basic_2x2();
    test_k0();
    test_n0();
    test_sign_floor();
    test_overflow_wrap();
    test_go_ignored();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
